// File: rtl/ysyx_22041207_div.sv
// Multi-cycle 64/32-bit integer divider (DIV/DIVU/REM/REMU and W variants).
// Radix-2 restoring iteration on magnitudes, fixed latency, sign fix-up in a final cycle.
module ysyx_22041207_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid,
    input  logic        flush,
    input  logic        div_signed,
    input  logic        divw,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        div_ready,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] dsr_q, dsr_d;
    logic [63:0] dvd_q, dvd_d;
    logic        divw_q, divw_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dzero_q, dzero_d;
    logic [63:0] quotient_q, quotient_d;
    logic [63:0] remainder_q, remainder_d;

    logic        accept;
    logic        last_iter;
    logic [63:0] a_ext, b_ext, a_mag, b_mag;
    logic        a_neg, b_neg;
    logic [64:0] trial;
    logic [65:0] diff;
    logic        ge;
    logic [63:0] q_s, r_s;

    assign accept    = (state_q == IDLE) && div_valid && !flush;
    assign last_iter = (cnt_q == (divw_q ? 7'd32 : 7'd64));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            dvd_q       <= '0;
            divw_q      <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dzero_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            dvd_q       <= dvd_d;
            divw_q      <= divw_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            dzero_q     <= dzero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (flush) state_d = IDLE;
                     else if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_ready = (state_q == IDLE);
        out_valid = (state_q == DONE) && !flush;
    end

    always_comb begin
        a_ext = divw ? (div_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]})
                     : dividend;
        b_ext = divw ? (div_signed ? {{32{divisor[31]}}, divisor[31:0]} : {32'b0, divisor[31:0]})
                     : divisor;
        a_neg = div_signed & a_ext[63];
        b_neg = div_signed & b_ext[63];
        a_mag = a_neg ? 64'd0 - a_ext : a_ext;
        b_mag = b_neg ? 64'd0 - b_ext : b_ext;

        trial = {rem_q, quo_q[63]};
        diff  = {1'b0, trial} - {2'b0, dsr_q};
        ge    = ~diff[65];

        // Special cases: divide-by-zero overrides; signed overflow falls out of the magnitude path.
        q_s = qneg_q ? 64'd0 - quo_q : quo_q;
        r_s = rneg_q ? 64'd0 - rem_q : rem_q;
        if (dzero_q) begin
            q_s = '1;
            r_s = dvd_q;
        end
        if (divw_q) begin
            q_s = {{32{q_s[31]}}, q_s[31:0]};
            r_s = {{32{r_s[31]}}, r_s[31:0]};
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        dvd_d       = dvd_q;
        divw_d      = divw_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        dzero_d     = dzero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (accept) begin
            cnt_d   = '0;
            rem_d   = '0;
            // Word ops start with the magnitude in the upper half so 32 shifts consume it.
            quo_d   = divw ? {a_mag[31:0], 32'b0} : a_mag;
            dsr_d   = b_mag;
            dvd_d   = a_ext;
            divw_d  = divw;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dzero_d = (b_ext == 64'd0);
        end else if (state_q == BUSY && !flush) begin
            if (last_iter) begin
                quotient_d  = q_s;
                remainder_d = r_s;
            end else begin
                cnt_d = cnt_q + 7'd1;
                rem_d = ge ? diff[63:0] : trial[63:0];
                quo_d = {quo_q[62:0], ge};
            end
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: doc/ysyx_22041207_div.md
YSYX_22041207_DIV -- requirements
Module: ysyx_22041207_div

Interface
REQ-001 Parameters: none; data width fixed at 64 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 div_valid  input  1  request from ALU; operands and mode are valid.
REQ-005 flush  input  1  pipeline flush; aborts any in-flight divide.
REQ-006 div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-007 divw  input  1  1 = 32-bit word op on operand bits [31:0].
REQ-008 dividend  input  64  dividend.
REQ-009 divisor  input  64  divisor.
REQ-010 div_ready  output  1  block idle; a request is accepted this cycle.
REQ-011 out_valid  output  1  one-cycle pulse; quotient and remainder are valid.
REQ-012 quotient  output  64  quotient result.
REQ-013 remainder  output  64  remainder result.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; div_ready SHALL be 1 only in IDLE.
REQ-015 Accept: div_valid=1, div_ready=1 and flush=0 at edge k latch the operands and mode, then go IDLE->BUSY.
REQ-016 Operands SHALL be sampled only at accept; input changes during BUSY SHALL have no effect.
REQ-017 BUSY SHALL run a radix-2 restoring iteration on magnitudes, one quotient bit per cycle: N=64 iterations, or N=32 when divw=1.
REQ-018 An iteration counter SHALL step the iterations; BUSY->DONE after the Nth iteration.
REQ-019 out_valid SHALL be 1 for exactly the one cycle after edge k+N+1 (DONE); DONE->IDLE at the next edge.
REQ-020 Latency SHALL be fixed: 65 cycles for 64-bit ops and 33 cycles for divw, including special cases.
REQ-021 Signed mode: take operand magnitudes; quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-022 divw=1: operands are bits [31:0] (sign- or zero-extended per div_signed); both 32-bit results SHALL be sign-extended to 64 bits.
REQ-023 Divide by zero: quotient = all ones (at op width, then extended per REQ-022); remainder = dividend (at op width, then extended).
REQ-024 Signed overflow (most-negative / -1 at op width): quotient = dividend, remainder = 0.
REQ-025 quotient and remainder SHALL hold their last values until the next out_valid.
REQ-026 flush=1 in BUSY or DONE: go to IDLE at that edge; no out_valid for the aborted op.
REQ-027 flush=1 with div_valid=1 in IDLE: the request SHALL NOT be accepted.
REQ-028 div_valid in BUSY or DONE SHALL be ignored, not queued.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE and clear the counter, div_ready=1, out_valid=0, quotient=0 and remainder=0.
REQ-030 rst SHALL take priority over flush and div_valid, including mid-operation; no out_valid follows reset.

Verification
REQ-031 Unsigned 64-bit: dividend=100, divisor=7 at edge 0 -> out_valid after edge 65, quotient=14, remainder=2, div_ready=0 for edges 1..66.
REQ-032 Signed: -7 / 2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF.
REQ-033 Divide by zero, unsigned: 0x1234 / 0 -> quotient=0xFFFFFFFFFFFFFFFF, remainder=0x1234, latency 65.
REQ-034 Signed overflow: 0x8000000000000000 / -1 -> quotient=0x8000000000000000, remainder=0.
REQ-035 divw signed: low words 0x80000000 / 0xFFFFFFFF -> out_valid after edge 33, quotient=0xFFFFFFFF80000000, remainder=0.
REQ-036 flush at edge 10 of a 64-bit op -> div_ready=1 after edge 10, no out_valid, and a new request at edge 11 completes after edge 76; rst at edge 20 of an op gives the same abort with both outputs cleared to 0.
